// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator statistics stage: comparator result
// codes, the snapshot handshake states and the default counter width.
package cmp_pkg;

  localparam int CNT_W_DEFAULT = 8;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } snap_state_t;

  // A result is well formed only when exactly one of g/e/l is asserted.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping, with a
// synchronous clear that takes priority over the increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_stat_counter.sv
// Statistics stage behind the 4-bit magnitude comparator: per-category counts,
// longest equal run, malformed-code tracking and a req/ack frozen snapshot.
module cmp_stat_counter
  import cmp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             g,
  input  logic             e,
  input  logic             l,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] eq_run_max,
  output logic             err_sticky,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_gt,
  output logic [CNT_W-1:0] snap_eq,
  output logic [CNT_W-1:0] snap_lt,
  output logic [CNT_W-1:0] snap_err,
  output logic [CNT_W-1:0] snap_run
);

  logic [2:0]       code;
  logic             hit_gt;
  logic             hit_eq;
  logic             hit_lt;
  logic             hit_err;
  logic [CNT_W-1:0] eq_run;
  logic [CNT_W-1:0] eq_run_inc;
  snap_state_t      state;
  snap_state_t      state_next;
  logic             capture;

  assign code       = {g, e, l};
  assign hit_gt     = in_valid && (code == CMP_GT);
  assign hit_eq     = in_valid && (code == CMP_EQ);
  assign hit_lt     = in_valid && (code == CMP_LT);
  assign hit_err    = in_valid && !is_legal_code(code);
  assign eq_run_inc = (eq_run == '1) ? eq_run : eq_run + 1'b1;

  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .inc(hit_gt), .clr(clr), .count(gt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .inc(hit_eq), .clr(clr), .count(eq_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .inc(hit_lt), .clr(clr), .count(lt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .inc(hit_err), .clr(clr), .count(err_cnt)
  );

  // Idle cycles (in_valid=0) neither extend nor break the current equal run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_run     <= '0;
      eq_run_max <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      eq_run     <= '0;
      eq_run_max <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (hit_eq) begin
        eq_run <= eq_run_inc;
        if (eq_run_inc > eq_run_max) begin
          eq_run_max <= eq_run_inc;
        end
      end else if (in_valid) begin
        eq_run <= '0;
      end
      if (hit_err) begin
        err_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:  if (snap_req) state_next = ST_HELD;
      ST_HELD: if (snap_ack) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    capture    = (state == ST_RUN) && snap_req;
    snap_valid = (state == ST_HELD);
  end

  // Captures the registered live values, so the same-cycle sample and any
  // same-cycle clear are both excluded from the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_gt  <= '0;
      snap_eq  <= '0;
      snap_lt  <= '0;
      snap_err <= '0;
      snap_run <= '0;
    end else if (capture) begin
      snap_gt  <= gt_cnt;
      snap_eq  <= eq_cnt;
      snap_lt  <= lt_cnt;
      snap_err <= err_cnt;
      snap_run <= eq_run_max;
    end
  end

endmodule

// File: tb/tb_cmp_stat_counter.sv
// Directed, table-driven bench for cmp_stat_counter with hand-written
// sequences for saturation, the snapshot handshake and asynchronous reset.
module tb_cmp_stat_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         g = 1'b0;
  logic         e = 1'b0;
  logic         l = 1'b0;
  logic         clr = 1'b0;
  logic         snap_req = 1'b0;
  logic         snap_ack = 1'b0;
  logic [W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt, eq_run_max;
  logic         err_sticky, snap_valid;
  logic [W-1:0] snap_gt, snap_eq, snap_lt, snap_err, snap_run;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic       clr;
    int         gt;
    int         eq;
    int         lt;
    int         err;
    int         runmax;
    int         sticky;
  } vec_t;

  vec_t vecs[25];

  cmp_stat_counter #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .g(g), .e(e), .l(l),
    .clr(clr), .snap_req(snap_req), .snap_ack(snap_ack),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
    .eq_run_max(eq_run_max), .err_sticky(err_sticky), .snap_valid(snap_valid),
    .snap_gt(snap_gt), .snap_eq(snap_eq), .snap_lt(snap_lt),
    .snap_err(snap_err), .snap_run(snap_run)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] code, input logic c,
                              input int gt, input int eq, input int lt,
                              input int err, input int runmax, input int sticky);
    vec_t r;
    r.v = v; r.code = code; r.clr = c;
    r.gt = gt; r.eq = eq; r.lt = lt; r.err = err; r.runmax = runmax; r.sticky = sticky;
    return r;
  endfunction

  // Drives one cycle of inputs, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] code, input logic c,
                               input logic req, input logic ack);
    in_valid = v;
    {g, e, l} = code;
    clr = c;
    snap_req = req;
    snap_ack = ack;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {g, e, l} = 3'b000;
    clr = 1'b0;
    snap_req = 1'b0;
    snap_ack = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 3'b100, 0, 2, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 3'b100, 0, 3, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 3'b100, 0, 4, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 3'b100, 0, 5, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 3'b010, 0, 5, 1, 0, 0, 1, 0);
    vecs[6]  = mk(1, 3'b010, 0, 5, 2, 0, 0, 2, 0);
    vecs[7]  = mk(1, 3'b010, 0, 5, 3, 0, 0, 3, 0);
    vecs[8]  = mk(1, 3'b001, 0, 5, 3, 1, 0, 3, 0);
    vecs[9]  = mk(1, 3'b001, 0, 5, 3, 2, 0, 3, 0);
    vecs[10] = mk(1, 3'b100, 1, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 3'b011, 0, 0, 0, 0, 1, 0, 1);
    vecs[12] = mk(1, 3'b000, 0, 0, 0, 0, 2, 0, 1);
    vecs[13] = mk(0, 3'b100, 0, 0, 0, 0, 2, 0, 1);
    vecs[14] = mk(1, 3'b010, 0, 0, 1, 0, 2, 1, 1);
    vecs[15] = mk(1, 3'b010, 0, 0, 2, 0, 2, 2, 1);
    vecs[16] = mk(0, 3'b010, 0, 0, 2, 0, 2, 2, 1);
    vecs[17] = mk(1, 3'b010, 0, 0, 3, 0, 2, 3, 1);
    vecs[18] = mk(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 3'b010, 0, 0, 1, 0, 0, 1, 0);
    vecs[20] = mk(1, 3'b010, 0, 0, 2, 0, 0, 2, 0);
    vecs[21] = mk(1, 3'b110, 0, 0, 2, 0, 1, 2, 1);
    vecs[22] = mk(1, 3'b010, 0, 0, 3, 0, 1, 2, 1);
    vecs[23] = mk(1, 3'b111, 0, 0, 3, 0, 2, 2, 1);
    vecs[24] = mk(1, 3'b101, 0, 0, 3, 0, 3, 2, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset gt_cnt", gt_cnt, 0);
    checkOutput("reset err_cnt", err_cnt, 0);
    checkOutput("reset eq_run_max", eq_run_max, 0);
    checkOutput("reset err_sticky", err_sticky, 0);
    checkOutput("reset snap_valid", snap_valid, 0);
    checkOutput("reset snap_gt", snap_gt, 0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].v, vecs[i].code, vecs[i].clr, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d gt_cnt", i), gt_cnt, vecs[i].gt);
      checkOutput($sformatf("vec%0d eq_cnt", i), eq_cnt, vecs[i].eq);
      checkOutput($sformatf("vec%0d lt_cnt", i), lt_cnt, vecs[i].lt);
      checkOutput($sformatf("vec%0d err_cnt", i), err_cnt, vecs[i].err);
      checkOutput($sformatf("vec%0d eq_run_max", i), eq_run_max, vecs[i].runmax);
      checkOutput($sformatf("vec%0d err_sticky", i), err_sticky, vecs[i].sticky);
    end

    // Saturation: 300 equal results must stick at 255.
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("sat eq_cnt", eq_cnt, 255);
    checkOutput("sat eq_run_max", eq_run_max, 255);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("sat eq_cnt after lt", eq_cnt, 255);
    checkOutput("sat eq_run_max after lt", eq_run_max, 255);
    checkOutput("sat lt_cnt", lt_cnt, 1);

    // Snapshot handshake.
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
    checkOutput("snap1 gt_cnt", gt_cnt, 5);
    checkOutput("snap1 snap_valid", snap_valid, 1);
    checkOutput("snap1 snap_gt", snap_gt, 4);
    checkOutput("snap1 snap_eq", snap_eq, 2);
    checkOutput("snap1 snap_run", snap_run, 2);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    checkOutput("held gt_cnt", gt_cnt, 7);
    checkOutput("held snap_gt", snap_gt, 4);
    checkOutput("held snap_valid", snap_valid, 1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("ack snap_valid", snap_valid, 0);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("ack in run snap_valid", snap_valid, 0);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("snap2 snap_valid", snap_valid, 1);
    checkOutput("snap2 snap_gt", snap_gt, 7);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    checkOutput("ack+req snap_valid", snap_valid, 0);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("ack+req dropped snap_valid", snap_valid, 0);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    checkOutput("req+clr snap_gt", snap_gt, 7);
    checkOutput("req+clr snap_eq", snap_eq, 2);
    checkOutput("req+clr gt_cnt", gt_cnt, 0);
    checkOutput("req+clr eq_cnt", eq_cnt, 0);
    checkOutput("req+clr snap_valid", snap_valid, 1);
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
    checkOutput("held err_sticky", err_sticky, 1);
    applyStimulus(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
    checkOutput("clr+gt gt_cnt", gt_cnt, 0);
    checkOutput("clr+gt err_cnt", err_cnt, 0);
    checkOutput("clr+gt err_sticky", err_sticky, 0);
    checkOutput("clr+gt snap_gt", snap_gt, 7);
    checkOutput("clr+gt snap_valid", snap_valid, 1);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    checkOutput("pre-rst gt_cnt", gt_cnt, 1);

    // Asynchronous reset between clock edges while HELD.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst snap_valid", snap_valid, 0);
    checkOutput("async rst snap_gt", snap_gt, 0);
    checkOutput("async rst snap_eq", snap_eq, 0);
    checkOutput("async rst gt_cnt", gt_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("post rst snap_valid", snap_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cmp_stat_counter.md
# cmp_stat_counter

Downstream statistics stage for the 4-bit magnitude comparator. Each cycle it consumes one strobed greater/equal/lesser result, keeps saturating per-category counts, tracks the longest run of consecutive equal results, and flags malformed result codes. A request/acknowledge handshake freezes a coherent snapshot of all statistics for a slower reader.

## Interface
- CNT_W, 8, width of every counter and run-length register
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  g/e/l are a valid comparator result this cycle
- g, e, l  in  1 each  comparator outputs: greater, equal, lesser
- clr  in  1  one-cycle pulse that zeroes live statistics
- snap_req  in  1  one-cycle pulse that requests a snapshot
- snap_ack  in  1  reader has consumed the snapshot
- gt_cnt, eq_cnt, lt_cnt, err_cnt  out  CNT_W each  live counts
- eq_run_max  out  CNT_W  live longest equal run
- err_sticky  out  1  set on the first malformed code, cleared only by clr or rst
- snap_valid  out  1  snapshot registers hold valid data
- snap_gt, snap_eq, snap_lt, snap_err, snap_run  out  CNT_W each  frozen copies

## Operation
- Legal code: in_valid=1 with exactly one of g/e/l high (100, 010, 001).
- Legal g: gt_cnt+1. Legal l: lt_cnt+1. Legal e: eq_cnt+1.
- Illegal code (000, 011, 101, 110, 111 with in_valid=1): err_cnt+1 and err_sticky set. No category counter changes, and eq_run resets to 0.
- All counters saturate at 2^CNT_W-1 and never wrap.
- eq_run is internal. A legal e gives eq_run <= sat(eq_run+1) and eq_run_max <= max(eq_run_max, sat(eq_run+1)) on the same edge. Any other valid code gives eq_run <= 0. A cycle with in_valid=0 leaves eq_run unchanged.
- clr zeroes all live counters, eq_run, eq_run_max and err_sticky. A sample presented in the same cycle is discarded (clr wins). clr does not affect the snapshot registers or snap_valid.
- FSM has two states, RUN and HELD:
  - RUN with snap_req: copy pre-update live values (excluding the same-cycle sample) into snap_*, set snap_valid, go to HELD.
  - HELD: live counting continues. snap_* stay frozen. snap_req is ignored.
  - HELD with snap_ack: clear snap_valid, return to RUN.
  - snap_ack in RUN is ignored.
- snap_req and clr in the same cycle: the snapshot captures pre-clear values, then live values clear.

## Timing
- Reset values: every counter, eq_run, eq_run_max and all snap_* are 0. err_sticky=0, snap_valid=0, FSM=RUN.
- rst mid-operation, including HELD, returns to these values immediately and asynchronously.
- Sample-to-count latency: 1 cycle. Counters update on the edge where in_valid is sampled.
- snap_valid rises 1 cycle after snap_req and falls 1 cycle after snap_ack.
- In HELD, snap_ack together with snap_req: the ack is honoured, the req is dropped, and the FSM is in RUN next cycle.
- Fully synchronous apart from rst. No combinational path from inputs to outputs.

## Structure
- Shared package cmp_pkg holds:
  - The state enum for RUN/HELD.
  - The 3-bit g/e/l code constants CMP_GT=100, CMP_EQ=010, CMP_LT=001.
  - CNT_W default.
- One natural sub-module, sat_counter (parameter CNT_W; inputs inc and clr; output count), instantiated four times for gt, eq, lt and err.
- eq_run logic, the FSM and the snapshot registers live in the top level.

## Test plan
- Reset, then feed 5 GT, 3 EQ, 2 LT with in_valid=1 -> gt_cnt=5, eq_cnt=3, lt_cnt=2, err_cnt=0, eq_run_max=3.
- CNT_W=8, 300 consecutive EQ -> eq_cnt=255, eq_run_max=255, no wrap. One LT, then 2 EQ -> eq_run_max stays 255.
- Codes 011 and 000 with in_valid=1, and 100 with in_valid=0 -> err_cnt=2, err_sticky=1, gt_cnt=0.
- EQ,EQ, then a gap with in_valid=0, then EQ -> eq_run_max=3. EQ,EQ, then an illegal code, then EQ -> eq_run_max=2.
- With gt_cnt=4: snap_req together with a GT sample -> snap_gt=4, gt_cnt=5, snap_valid=1 next cycle. Two more GT plus a second snap_req -> snap_gt still 4. snap_ack -> snap_valid=0 next cycle.
- clr with a GT sample in the same cycle -> all live counts 0 and err_sticky=0; snapshot unchanged. Then assert rst while in HELD -> snap_valid=0 and all outputs 0 immediately.
